// File: rtl/conv_loader.sv
// Loads one tensor+weight stream into the convolution core RAMs, then starts the core and waits for w_done.
// Optional CONV_LOADER_CHECKSUM_EN adds a running modular sum of accepted stream words.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 4
`endif
`ifndef KERNEL_NUMS_SIZE
`define KERNEL_NUMS_SIZE 8
`endif

module conv_loader #(
  parameter int T_BASE_ADDR = 0,
  parameter int W_BASE_ADDR = 0,
  parameter int START_GAP   = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [`TENSOR_SIZE-1:0]       cfg_tensor_size,
  input  logic [`KERNEL_SIZE-1:0]       cfg_kernel_size,
  input  logic [`CHANNELS_SIZE-1:0]     cfg_channels,
  input  logic [`STRIDE_SIZE-1:0]       cfg_stride,
  input  logic [`KERNEL_NUMS_SIZE-1:0]  cfg_kernel_nums,
  input  logic [`DATA_WIDTH-1:0]        s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          t_ena,
  output logic                          t_wea,
  output logic [`ADDR_SIZE-1:0]         t_addr,
  output logic [`DATA_WIDTH-1:0]        t_din,
  output logic                          w_ena,
  output logic                          w_wea,
  output logic [`ADDR_SIZE-1:0]         w_addr,
  output logic [`DATA_WIDTH-1:0]        w_din,
  output logic [`TENSOR_SIZE-1:0]       tensor_size,
  output logic [`KERNEL_SIZE-1:0]       kernel_size,
  output logic [`CHANNELS_SIZE-1:0]     channels,
  output logic [`STRIDE_SIZE-1:0]       stride,
  output logic [`KERNEL_NUMS_SIZE-1:0]  kernel_nums,
  output logic                          start,
  input  logic                          conv_w_done,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [3:0]                    state_dbg
`ifdef CONV_LOADER_CHECKSUM_EN
  ,
  output logic [`DATA_WIDTH+7:0]        checksum
`endif
);

  localparam int AW    = `ADDR_SIZE;
  localparam int LEN_W = 2*`TENSOR_SIZE + `CHANNELS_SIZE + 2*`KERNEL_SIZE + `KERNEL_NUMS_SIZE + `ADDR_SIZE;
  localparam logic [LEN_W-1:0] ADDR_SPAN = LEN_W'(1) << `ADDR_SIZE;

  typedef enum logic [3:0] {
    S_IDLE, S_CALC1, S_CALC2, S_LOAD_T, S_LOAD_W, S_GAP, S_START, S_WAIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q;
  logic [3:0]        gap_q;
  logic [LEN_W-1:0]  t_len_q, w_len_q;
  logic              cfg_fire, hs, t_last, w_last, cfg_bad, err_d;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready depends only on the FSM state, never on valid, so the upstream may hold valid freely.
  assign cfg_ready = rstn && (state_q == S_IDLE);
  assign s_ready   = (state_q == S_LOAD_T) || (state_q == S_LOAD_W);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign hs        = s_valid && s_ready;
  assign start     = (state_q == S_START);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

  assign t_last  = (LEN_W'(cnt_q) == t_len_q - LEN_W'(1));
  assign w_last  = (LEN_W'(cnt_q) == w_len_q - LEN_W'(1));
  assign cfg_bad = (kernel_size == '0) || (stride == '0) || (channels == '0) ||
                   (kernel_nums == '0) || (LEN_W'(kernel_size) > LEN_W'(tensor_size)) ||
                   (t_len_q > ADDR_SPAN) || (w_len_q > ADDR_SPAN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE:   if (cfg_fire) state_d = S_CALC1;
      S_CALC1:  state_d = S_CALC2;
      S_CALC2: begin
        if (cfg_bad) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_LOAD_T;
        end
      end
      S_LOAD_T: if (hs && t_last) state_d = S_LOAD_W;
      S_LOAD_W: if (hs && w_last) state_d = S_GAP;
      // The first GAP cycle is the one carrying the last weight write.
      S_GAP:    if (gap_q == 4'(START_GAP)) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (conv_w_done) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      gap_q       <= '0;
      t_len_q     <= '0;
      w_len_q     <= '0;
      tensor_size <= '0;
      kernel_size <= '0;
      channels    <= '0;
      stride      <= '0;
      kernel_nums <= '0;
      t_ena       <= 1'b0;
      t_wea       <= 1'b0;
      t_addr      <= '0;
      t_din       <= '0;
      w_ena       <= 1'b0;
      w_wea       <= 1'b0;
      w_addr      <= '0;
      w_din       <= '0;
      err         <= 1'b0;
    end else begin
      t_ena <= 1'b0;
      t_wea <= 1'b0;
      w_ena <= 1'b0;
      w_wea <= 1'b0;
      err   <= err_d;
      if (cfg_fire) begin
        tensor_size <= cfg_tensor_size;
        kernel_size <= cfg_kernel_size;
        channels    <= cfg_channels;
        stride      <= cfg_stride;
        kernel_nums <= cfg_kernel_nums;
        cnt_q       <= '0;
      end
      if (state_q == S_CALC1) begin
        t_len_q <= LEN_W'(tensor_size) * LEN_W'(tensor_size) * LEN_W'(channels);
        w_len_q <= LEN_W'(kernel_size) * LEN_W'(kernel_size) * LEN_W'(channels) *
                   LEN_W'(kernel_nums);
      end
      if (hs && state_q == S_LOAD_T) begin
        t_ena  <= 1'b1;
        t_wea  <= 1'b1;
        t_addr <= AW'(T_BASE_ADDR) + cnt_q;
        t_din  <= s_data;
        cnt_q  <= t_last ? '0 : cnt_q + 1'b1;
      end
      if (hs && state_q == S_LOAD_W) begin
        w_ena  <= 1'b1;
        w_wea  <= 1'b1;
        w_addr <= AW'(W_BASE_ADDR) + cnt_q;
        w_din  <= s_data;
        cnt_q  <= w_last ? '0 : cnt_q + 1'b1;
      end
      gap_q <= (state_q == S_GAP) ? gap_q + 1'b1 : '0;
    end
  end

`ifdef CONV_LOADER_CHECKSUM_EN
  localparam int CW = `DATA_WIDTH + 8;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         checksum <= '0;
    else if (cfg_fire) checksum <= '0;
    else if (hs)       checksum <= checksum + CW'(s_data);
  end
`endif

endmodule

// File: tb/tb_conv_loader.sv
// Directed bench for conv_loader: RAM write scoreboard, timing of start/done/err, reset abort.
// Build with CONV_LOADER_CHECKSUM_EN to also check the stream checksum.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 4
`endif
`ifndef KERNEL_NUMS_SIZE
`define KERNEL_NUMS_SIZE 8
`endif

module tb_conv_loader;
  localparam int DW = `DATA_WIDTH;
  localparam int AW = `ADDR_SIZE;
  localparam int EW = AW + DW + 1;

  logic                          clk, rstn;
  logic                          cfg_valid, cfg_ready;
  logic [`TENSOR_SIZE-1:0]       cfg_tensor_size;
  logic [`KERNEL_SIZE-1:0]       cfg_kernel_size;
  logic [`CHANNELS_SIZE-1:0]     cfg_channels;
  logic [`STRIDE_SIZE-1:0]       cfg_stride;
  logic [`KERNEL_NUMS_SIZE-1:0]  cfg_kernel_nums;
  logic [DW-1:0]                 s_data;
  logic                          s_valid, s_ready;
  logic                          t_ena, t_wea, w_ena, w_wea;
  logic [AW-1:0]                 t_addr, w_addr;
  logic [DW-1:0]                 t_din, w_din;
  logic [`TENSOR_SIZE-1:0]       tensor_size;
  logic [`KERNEL_SIZE-1:0]       kernel_size;
  logic [`CHANNELS_SIZE-1:0]     channels;
  logic [`STRIDE_SIZE-1:0]       stride;
  logic [`KERNEL_NUMS_SIZE-1:0]  kernel_nums;
  logic                          start, conv_w_done, busy, done, err;
  logic [3:0]                    state_dbg;
`ifdef CONV_LOADER_CHECKSUM_EN
  logic [DW+7:0]                 checksum;
`endif

  conv_loader #(.T_BASE_ADDR(0), .W_BASE_ADDR(0), .START_GAP(2)) dut (
    .clk(clk), .rstn(rstn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tensor_size(cfg_tensor_size), .cfg_kernel_size(cfg_kernel_size),
    .cfg_channels(cfg_channels), .cfg_stride(cfg_stride), .cfg_kernel_nums(cfg_kernel_nums),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .t_ena(t_ena), .t_wea(t_wea), .t_addr(t_addr), .t_din(t_din),
    .w_ena(w_ena), .w_wea(w_wea), .w_addr(w_addr), .w_din(w_din),
    .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels),
    .stride(stride), .kernel_nums(kernel_nums),
    .start(start), .conv_w_done(conv_w_done), .busy(busy), .done(done), .err(err),
    .state_dbg(state_dbg)
`ifdef CONV_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  int wr_total    = 0;
  int wr_cyc[512];
  int start_total = 0;
  int start_cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] obs;
    if (rstn) begin
      if (t_ena || w_ena) begin
        check("t_w_exclusive", 64'(t_ena & w_ena), 0);
        check("start_vs_write", 64'(start), 0);
        check("wea_follows_ena", 64'(t_ena ? t_wea : w_wea), 1);
        obs = t_ena ? {1'b0, t_addr, t_din} : {1'b1, w_addr, w_din};
        if (exp_q.size() == 0) check("write_when_none_expected", 64'({t_ena, w_ena}), 0);
        else                   check("ram_write", 64'(obs), 64'(exp_q.pop_front()));
        if (wr_total < 512) wr_cyc[wr_total] = cyc;
        wr_total++;
      end
      if (start) begin
        start_total++;
        start_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic send_cfg(input int ts, input int ks, input int ch, input int st, input int kn);
    @(negedge clk);
    cfg_tensor_size = `TENSOR_SIZE'(ts);
    cfg_kernel_size = `KERNEL_SIZE'(ks);
    cfg_channels    = `CHANNELS_SIZE'(ch);
    cfg_stride      = `STRIDE_SIZE'(st);
    cfg_kernel_nums = `KERNEL_NUMS_SIZE'(kn);
    cfg_valid       = 1'b1;
    for (int i = 0; i < 20 && !cfg_ready; i++) @(negedge clk);
    check("cfg_ready_at_offer", 64'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic stream(input int first, input int n, input bit toggle);
    int k = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (k < n && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (toggle && ph) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = DW'(first + k);
        if (s_ready) k++;
      end
      ph = ~ph;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("stream_words_accepted", 64'(k), 64'(n));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cfg_ready"}, 64'(cfg_ready), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_s_ready"}, 64'(s_ready), 0);
    check({tag, "_ram_ena"}, 64'({t_ena, w_ena, t_wea, w_wea}), 0);
    check({tag, "_ram_addr"}, 64'({t_addr, w_addr}), 0);
    check({tag, "_pulses"}, 64'({start, done, err}), 0);
    check({tag, "_cfg_outs"}, 64'({tensor_size, kernel_size, channels, stride, kernel_nums}), 0);
    check({tag, "_state"}, 64'(state_dbg), 0);
  endtask

  // Config 4/2/1/1/2: 16 tensor words then 8 weight words taken from stream first..first+23.
  task automatic run_load(input string tag, input int first, input bit toggle, input int span);
    int base = wr_total;
    int sbase = start_total;
    int sum = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 16) exp_q.push_back({1'b0, AW'(i), DW'(first + i)});
      else        exp_q.push_back({1'b1, AW'(i - 16), DW'(first + i)});
      sum += first + i;
    end
    send_cfg(4, 2, 1, 1, 2);
    check({tag, "_cfg_captured"}, 64'({tensor_size, kernel_size, channels, stride, kernel_nums}),
          64'({8'd4, 4'd2, 8'd1, 4'd1, 8'd2}));
    fork
      stream(first, 24, toggle);
      begin
        repeat (6) @(negedge clk);
        conv_w_done = toggle;
        @(negedge clk);
        conv_w_done = 1'b0;
      end
    join
    for (int i = 0; i < 40 && start_total == sbase; i++) @(negedge clk);
    check({tag, "_start_seen"}, 64'(start_total - sbase), 1);
    check({tag, "_write_count"}, 64'(wr_total - base), 24);
    check({tag, "_start_gap"}, 64'(start_cyc - wr_cyc[base + 23]), 3);
    check({tag, "_load_span"}, 64'(wr_cyc[base + 23] - wr_cyc[base]), 64'(span));
    check({tag, "_cfg_held"}, 64'({tensor_size, kernel_size, channels, stride, kernel_nums}),
          64'({8'd4, 4'd2, 8'd1, 4'd1, 8'd2}));
    repeat (10) @(negedge clk);
    check({tag, "_waiting"}, 64'({busy, done}), 64'(2'b10));
    conv_w_done = 1'b1;
    @(negedge clk);
    conv_w_done = 1'b0;
    check({tag, "_done_pulse"}, 64'(done), 1);
`ifdef CONV_LOADER_CHECKSUM_EN
    check({tag, "_checksum"}, 64'(checksum), 64'(sum));
`endif
    @(negedge clk);
    check({tag, "_after_done"}, 64'({done, busy, cfg_ready}), 64'(3'b001));
    check({tag, "_single_start"}, 64'(start_total - sbase), 1);
  endtask

  task automatic err_case(input string tag, input int ts, input int ks, input int ch,
                          input int st, input int kn);
    int base = wr_total;
    int sbase = start_total;
    s_valid = 1'b1;
    s_data  = DW'(5);
    send_cfg(ts, ks, ch, st, kn);
    @(negedge clk);
    check({tag, "_err_early"}, 64'(err), 0);
    @(negedge clk);
    check({tag, "_err_pulse"}, 64'(err), 1);
    check({tag, "_cfg_ready_back"}, 64'(cfg_ready), 1);
    @(negedge clk);
    check({tag, "_err_one_cycle"}, 64'({err, busy}), 0);
    check({tag, "_no_writes"}, 64'(wr_total - base), 0);
    check({tag, "_no_start"}, 64'(start_total - sbase), 0);
    s_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    cfg_valid = 1'b0;
    cfg_tensor_size = '0;
    cfg_kernel_size = '0;
    cfg_channels = '0;
    cfg_stride = '0;
    cfg_kernel_nums = '0;
    s_data = '0;
    s_valid = 1'b0;
    conv_w_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(cfg_ready), 1);

    run_load("cont", 0, 1'b0, 23);
    run_load("toggle", 0, 1'b1, 46);

    err_case("k_gt_t", 4, 5, 1, 1, 1);
    err_case("stride0", 4, 2, 1, 0, 1);
    err_case("knums0", 4, 2, 1, 1, 0);
    err_case("ksize0", 4, 0, 1, 1, 1);
    err_case("chan0", 4, 2, 0, 1, 1);
    err_case("tlen_over", 17, 1, 1, 1, 1);
    err_case("wlen_over", 3, 3, 1, 1, 29);

    // T_LEN and W_LEN both exactly 2^ADDR_SIZE are legal; abort with reset afterwards.
    send_cfg(16, 4, 1, 1, 16);
    repeat (2) @(negedge clk);
    check("exact_span_no_err", 64'({err, s_ready}), 64'(2'b01));
    #2 rstn = 1'b0;
    #1 check_reset_outs("abort_idle");
    @(negedge clk);
    rstn = 1'b1;

    // reset in the middle of the tensor phase
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, AW'(i), DW'(100 + i)});
    send_cfg(4, 2, 1, 1, 2);
    stream(100, 7, 1'b0);
    #2 rstn = 1'b0;
    #1 check_reset_outs("midload");
    check("midload_writes_seen", 64'(exp_q.size()), 0);
    @(negedge clk);
    rstn = 1'b1;
    run_load("reload", 0, 1'b0, 23);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_loader.md
Name: conv_loader

Overview:
- Upstream feeder for the img2col/GEMM convolution core.
- Accepts a layer configuration, then one input data stream: the tensor words first, then the weight words.
- Writes those words into the tensor RAM and the weight RAM, holds the configuration stable, pulses the core's start, and waits for the core's w_done.
- Reports completion or configuration error to the host sequencer.

Parameters:
T_BASE_ADDR, 0, first tensor RAM address written
W_BASE_ADDR, 0, first weight RAM address written
START_GAP, 2, idle cycles between last RAM write and start pulse (1..15)

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous assert, active-low
cfg_valid  in  1  config offer
cfg_ready  out  1  high only in IDLE
cfg_tensor_size  in  `TENSOR_SIZE  input feature width/height
cfg_kernel_size  in  `KERNEL_SIZE  kernel width/height
cfg_channels  in  `CHANNELS_SIZE  channel count
cfg_stride  in  `STRIDE_SIZE  stride
cfg_kernel_nums  in  `KERNEL_NUMS_SIZE  kernel count
s_data  in  `DATA_WIDTH  load stream data
s_valid  in  1  stream valid
s_ready  out  1  stream ready
t_ena, t_wea  out  1 each  tensor RAM enable/write
t_addr  out  `ADDR_SIZE  tensor RAM address
t_din  out  `DATA_WIDTH  tensor RAM data
w_ena, w_wea  out  1 each  weight RAM enable/write
w_addr  out  `ADDR_SIZE  weight RAM address
w_din  out  `DATA_WIDTH  weight RAM data
tensor_size, kernel_size, channels, stride, kernel_nums  out  cfg widths  registered config to core
start  out  1  one-cycle start pulse to core
conv_w_done  in  1  core w_done
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle config-error pulse

Behaviour:
- Reset: all outputs are 0 (cfg_ready also 0 while rstn is low); FSM is IDLE; counters are cleared. Reset mid-load aborts with no done and no err; partial RAM contents are don't-care.
- Config capture: on cfg_valid && cfg_ready, the five cfg_* inputs are registered onto the config outputs and the FSM goes to CALC. Config outputs then stay constant until the next capture. cfg_valid outside IDLE is ignored.
- CALC (2 cycles):
  - Computes T_LEN = tensor_size² × channels and W_LEN = kernel_size² × channels × kernel_nums at full width.
  - Error → err pulse, back to IDLE, if any of: kernel_size = 0; stride = 0; kernel_size > tensor_size; channels = 0; kernel_nums = 0; T_LEN > 2^`ADDR_SIZE; W_LEN > 2^`ADDR_SIZE.
  - Otherwise → LOAD_T.
- LOAD_T:
  - s_ready = 1.
  - Each handshake writes one tensor RAM word: t_ena = t_wea = 1, t_addr = T_BASE_ADDR + cnt (mod 2^`ADDR_SIZE), t_din = s_data.
  - Write outputs are registered and appear the cycle after the handshake.
  - On the handshake with cnt = T_LEN−1: cnt clears, FSM → LOAD_W.
  - No s_valid: no write, counter holds.
- LOAD_W: same rules on the w_* port with W_BASE_ADDR and W_LEN; the last word → GAP.
- Stream order: word T_LEN+1 (the first weight word) must never land on the t_* port; s_ready is never high in any other state.
- GAP: counts START_GAP cycles after the cycle the last weight write is driven, then → START.
- START: start = 1 for exactly one cycle, then → WAIT.
- WAIT: waits for conv_w_done = 1 (sampled, level), then → DONE. conv_w_done outside WAIT is ignored.
- DONE: done = 1 for one cycle, then → IDLE; cfg_ready is high the next cycle.
- Never simultaneous: t_ena and w_ena; start and any RAM write.
- Throughput: one word per cycle at sustained s_valid.

Optional Feature:
- Macro: CONV_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum [`DATA_WIDTH+7:0] = modular sum of every accepted stream word (tensor and weight) since the last config capture; cleared on capture.
  - Valid when done pulses; held until the next capture.
- When undefined: no port, no logic.

Test Plan:
- tensor 4, kernel 2, channels 1, stride 1, kernel_nums 2; stream 0..23 with s_valid constant → 16 tensor writes (addr 0..15, data 0..15), 8 weight writes (addr 0..7, data 16..23); start pulses 3 cycles after the last write; conv_w_done asserted 10 cycles later → done pulse next cycle.
- Same config with s_valid toggling 1/0 every cycle → identical RAM contents; counters hold during gaps; total load time 48 cycles.
- kernel_size 5, tensor_size 4 → err pulse 2 cycles after capture; no RAM writes; no start; cfg_ready returns high.
- stride 0 or kernel_nums 0 → err pulse, no writes.
- rstn pulled low at tensor word 7 → all outputs 0 immediately; after release, a new config loads from addr 0 correctly.
- With CONV_LOADER_CHECKSUM_EN, stream 0..23 → checksum = 276 at the done pulse; conv_w_done pulsed during LOAD_T → ignored, FSM still waits in WAIT.
